otter_trap_ctrl: RTL

//  Trap sequencer for the OTTER MCU. Sits between the address/instruction checker and the PC/CSR

---
 rtl/otter_trap_ctrl_pkg.sv | 42 ++++
 rtl/otter_trap_ctrl_cause_decode.sv | 44 ++++
 rtl/otter_trap_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/otter_trap_ctrl_pkg.sv
// Shared encodings for the OTTER trap sequencer: exception selects, CSR addresses,
// cause codes, mstatus bit positions and FSM states.
package otter_trap_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned CAUSE_W = 31;

    localparam logic [3:0] MCAUSE_SEL_NONE           = 4'd0;
    localparam logic [3:0] MCAUSE_SEL_INSTR_MISALIGN = 4'd1;
    localparam logic [3:0] MCAUSE_SEL_ILLEGAL        = 4'd2;
    localparam logic [3:0] MCAUSE_SEL_LOAD_MISALIGN  = 4'd3;
    localparam logic [3:0] MCAUSE_SEL_STORE_MISALIGN = 4'd4;

    localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_ADDR_MTVAL   = 12'h343;

    localparam logic [CAUSE_W-1:0] CAUSE_INSTR_MISALIGN = 31'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL        = 31'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT     = 31'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGN  = 31'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGN = 31'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL          = 31'd11;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TRAP = 2'd1,
        S_MRET = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MTVAL_ZERO = 2'd0,
        MTVAL_TVAL = 2'd1,
        MTVAL_PC   = 2'd2
    } mtval_src_e;

endpackage

// File: rtl/otter_trap_ctrl_cause_decode.sv
// Combinational trap decode: prioritises irq > exception > ecall > ebreak and
// produces the take-trap strobe, the 31-bit cause and the mtval source.
module otter_trap_ctrl_cause_decode
    import otter_trap_ctrl_pkg::*;
#(
    parameter logic [30:0] INTR_CAUSE = 31'd11
) (
    input  logic               i_commit,
    input  logic [3:0]         i_excp_sel,
    input  logic               i_ecall,
    input  logic               i_ebreak,
    input  logic               i_irq,
    output logic               o_take_trap_c,
    output logic [CAUSE_W-1:0] o_cause_c,
    output mtval_src_e         o_mtval_src_c
);

    logic excp;

    always_comb begin
        excp          = (i_excp_sel != MCAUSE_SEL_NONE);
        o_take_trap_c = i_commit & (i_irq | excp | i_ecall | i_ebreak);
        o_cause_c     = '0;
        o_mtval_src_c = MTVAL_ZERO;
        if (i_irq) begin
            o_cause_c = INTR_CAUSE;
        end else if (excp) begin
            o_mtval_src_c = MTVAL_TVAL;
            // Unknown nonzero selects are reported as illegal instruction
            case (i_excp_sel)
                MCAUSE_SEL_INSTR_MISALIGN: o_cause_c = CAUSE_INSTR_MISALIGN;
                MCAUSE_SEL_LOAD_MISALIGN:  o_cause_c = CAUSE_LOAD_MISALIGN;
                MCAUSE_SEL_STORE_MISALIGN: o_cause_c = CAUSE_STORE_MISALIGN;
                default:                   o_cause_c = CAUSE_ILLEGAL;
            endcase
        end else if (i_ecall) begin
            o_cause_c = CAUSE_ECALL;
        end else if (i_ebreak) begin
            o_cause_c     = CAUSE_BREAKPOINT;
            o_mtval_src_c = MTVAL_PC;
        end
    end

endmodule

// File: rtl/otter_trap_ctrl.sv
// OTTER trap sequencer: owns the trap CSRs, takes traps/mret at commit and drives
// the two-cycle stall/kill/redirect sequence to the PC datapath.
module otter_trap_ctrl
    import otter_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [30:0] INTR_CAUSE  = 31'd11
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_commit,
    input  logic [XLEN-1:0] i_pc_addr,
    input  logic [3:0]      i_excp_sel,
    input  logic [XLEN-1:0] i_trap_mtval,
    input  logic            i_ecall,
    input  logic            i_ebreak,
    input  logic            i_mret,
    input  logic            i_intr,
    input  logic            i_csr_we,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_stall,
    output logic            o_kill,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_pc_target,
    output logic            o_mie
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   mtvec_q, mtvec_d;
    logic [XLEN-1:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [XLEN-1:0]   mtval_q, mtval_d;
    logic              mie_q, mie_d;
    logic              mpie_q, mpie_d;

    logic              irq;
    logic              run;
    logic              take_trap;
    logic              trap_go;
    logic              mret_go;
    logic [CAUSE_W-1:0] cause;
    mtval_src_e        mtval_src;

    assign irq     = i_intr & mie_q;
    assign run     = (state_q == S_RUN);
    assign trap_go = run & take_trap;
    assign mret_go = run & i_commit & i_mret & ~take_trap;

    otter_trap_ctrl_cause_decode #(
        .INTR_CAUSE (INTR_CAUSE)
    ) u_cause_decode (
        .i_commit      (i_commit),
        .i_excp_sel    (i_excp_sel),
        .i_ecall       (i_ecall),
        .i_ebreak      (i_ebreak),
        .i_irq         (irq),
        .o_take_trap_c (take_trap),
        .o_cause_c     (cause),
        .o_mtval_src_c (mtval_src)
    );

    // Next state: CSR writes first, trap/mret updates then override the same registers
    always_comb begin
        state_d  = state_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;

        if (run && i_csr_we) begin
            case (i_csr_addr)
                CSR_ADDR_MSTATUS: begin
                    mie_d  = i_csr_wdata[MSTATUS_MIE_BIT];
                    mpie_d = i_csr_wdata[MSTATUS_MPIE_BIT];
                end
                CSR_ADDR_MTVEC:  mtvec_d  = i_csr_wdata;
                CSR_ADDR_MEPC:   mepc_d   = {i_csr_wdata[XLEN-1:2], 2'b00};
                CSR_ADDR_MCAUSE: mcause_d = i_csr_wdata;
                CSR_ADDR_MTVAL:  mtval_d  = i_csr_wdata;
                default: ;
            endcase
        end

        case (state_q)
            S_RUN: begin
                if (trap_go) begin
                    mepc_d   = {i_pc_addr[XLEN-1:2], 2'b00};
                    mcause_d = {irq, cause};
                    case (mtval_src)
                        MTVAL_TVAL: mtval_d = i_trap_mtval;
                        MTVAL_PC:   mtval_d = i_pc_addr;
                        default:    mtval_d = '0;
                    endcase
                    mpie_d  = mie_q;
                    mie_d   = 1'b0;
                    state_d = S_TRAP;
                end else if (mret_go) begin
                    mie_d   = mpie_q;
                    mpie_d  = 1'b1;
                    state_d = S_MRET;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // Pipeline controls and CSR read mux; mcause already holds the new trap in S_TRAP
    always_comb begin
        o_stall     = 1'b0;
        o_kill      = 1'b0;
        o_redirect  = 1'b0;
        o_pc_target = '0;
        o_mie       = mie_q;
        o_csr_rdata = '0;

        case (state_q)
            S_RUN: begin
                o_kill  = trap_go;
                o_stall = trap_go | mret_go;
            end
            S_TRAP: begin
                o_stall     = 1'b1;
                o_redirect  = 1'b1;
                o_pc_target = {mtvec_q[XLEN-1:2], 2'b00};
                if (mtvec_q[1:0] == 2'b01 && mcause_q[XLEN-1])
                    o_pc_target = {mtvec_q[XLEN-1:2], 2'b00} + {mcause_q[XLEN-3:0], 2'b00};
            end
            S_MRET: begin
                o_stall     = 1'b1;
                o_redirect  = 1'b1;
                o_pc_target = mepc_q;
            end
            default: ;
        endcase

        case (i_csr_addr)
            CSR_ADDR_MSTATUS: begin
                o_csr_rdata[MSTATUS_MIE_BIT]  = mie_q;
                o_csr_rdata[MSTATUS_MPIE_BIT] = mpie_q;
            end
            CSR_ADDR_MTVEC:  o_csr_rdata = mtvec_q;
            CSR_ADDR_MEPC:   o_csr_rdata = mepc_q;
            CSR_ADDR_MCAUSE: o_csr_rdata = mcause_q;
            CSR_ADDR_MTVAL:  o_csr_rdata = mtval_q;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_RUN;
            mtvec_q  <= RESET_MTVEC;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
        end
    end

endmodule
